// File: rtl/memory_access_stage_pkg.sv
// Shared types for the fas2 MEM stage: access size encoding and the control bundle
// forwarded from execute through to writeback.
package memory_access_stage_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    typedef struct packed {
        logic      mem_read;
        logic      mem_write;
        mem_size_t mem_size;
        logic      mem_unsigned;
        logic      reg_write;
        logic      mem_to_reg;
    } control_type;

    function automatic logic is_mem_op(control_type c);
        return c.mem_read | c.mem_write;
    endfunction

endpackage

// File: rtl/memory_access_stage_align.sv
// Byte-lane steering for the data bus: store replication and byte enables,
// load lane extraction with sign/zero extension, and natural-alignment check.
module mem_lane_align
    import memory_access_stage_pkg::*;
(
    input  mem_size_t   size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] ld_data_i,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_be_o,
    output logic [31:0] ld_data_o,
    output logic        misalign_o
);

    logic [31:0] ld_shift;

    always_comb begin
        ld_shift   = ld_data_i >> {addr_lo_i, 3'b000};
        st_wdata_o = st_data_i;
        st_be_o    = 4'b1111;
        ld_data_o  = ld_shift;
        misalign_o = 1'b0;
        case (size_i)
            MEM_BYTE: begin
                st_wdata_o = {4{st_data_i[7:0]}};
                st_be_o    = 4'b0001 << addr_lo_i;
                ld_data_o  = {{24{~unsigned_i & ld_shift[7]}}, ld_shift[7:0]};
            end
            MEM_HALF: begin
                st_wdata_o = {2{st_data_i[15:0]}};
                st_be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                ld_data_o  = {{16{~unsigned_i & ld_shift[15]}}, ld_shift[15:0]};
                misalign_o = addr_lo_i[0];
            end
            default: misalign_o = |addr_lo_i;
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// fas2 MEM stage: issues at most one data-memory access at a time over a req/ack bus,
// stalls execute while waiting, and registers writeback results.
module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  control_type control_in,
    input  logic [31:0] alu_data_in,
    input  logic [31:0] memory_data_in,
    input  logic        overflow_in,
    input  logic        compflg_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output control_type wb_control,
    output logic [31:0] wb_result,
    output logic        wb_overflow,
    output logic        wb_compflg,
    output logic        misalign_err,
    output logic        bus_err
);

    localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t         state_q;
    logic [CNT_W-1:0] cnt_q;
    control_type    ctrl_q;
    logic [31:0]    addr_q;
    logic           ovf_q, cmp_q;

    // The aligner serves the incoming op in IDLE and the outstanding op in WAIT.
    control_type    op_ctrl;
    logic [1:0]     op_addr_lo;
    logic [31:0]    st_wdata, ld_ext;
    logic [3:0]     st_be;
    logic           misalign;
    control_type    fwd_ctrl;
    logic [31:0]    wait_result;

    always_comb begin
        op_ctrl    = (state_q == IDLE) ? control_in : ctrl_q;
        op_addr_lo = (state_q == IDLE) ? alu_data_in[1:0] : addr_q[1:0];
        fwd_ctrl   = control_in;
        fwd_ctrl.reg_write = control_in.reg_write & ~(is_mem_op(control_in) & misalign);
        wait_result = (ctrl_q.mem_read & ~ctrl_q.mem_write & ctrl_q.mem_to_reg) ? ld_ext : addr_q;
    end

    mem_lane_align u_align (
        .size_i     (op_ctrl.mem_size),
        .unsigned_i (op_ctrl.mem_unsigned),
        .addr_lo_i  (op_addr_lo),
        .st_data_i  (memory_data_in),
        .ld_data_i  (dmem_rdata),
        .st_wdata_o (st_wdata),
        .st_be_o    (st_be),
        .ld_data_o  (ld_ext),
        .misalign_o (misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ctrl_q       <= '0;
            addr_q       <= '0;
            ovf_q        <= 1'b0;
            cmp_q        <= 1'b0;
            ex_ready     <= 1'b1;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_be      <= '0;
            wb_valid     <= 1'b0;
            wb_control   <= '0;
            wb_result    <= '0;
            wb_overflow  <= 1'b0;
            wb_compflg   <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ex_valid) begin
                        if (is_mem_op(control_in) && !misalign) begin
                            state_q    <= WAIT;
                            ex_ready   <= 1'b0;
                            cnt_q      <= '0;
                            ctrl_q     <= control_in;
                            addr_q     <= alu_data_in;
                            ovf_q      <= overflow_in;
                            cmp_q      <= compflg_in;
                            dmem_req   <= 1'b1;
                            dmem_we    <= control_in.mem_write;
                            dmem_addr  <= {alu_data_in[31:2], 2'b00};
                            dmem_wdata <= st_wdata;
                            dmem_be    <= st_be;
                        end else begin
                            wb_valid     <= 1'b1;
                            wb_control   <= fwd_ctrl;
                            wb_result    <= alu_data_in;
                            wb_overflow  <= overflow_in;
                            wb_compflg   <= compflg_in;
                            misalign_err <= is_mem_op(control_in) & misalign;
                        end
                    end
                end
                WAIT: begin
                    // An ack arriving on the last permitted cycle still completes normally.
                    if (dmem_ack || cnt_q == CNT_LAST) begin
                        state_q     <= IDLE;
                        ex_ready    <= 1'b1;
                        dmem_req    <= 1'b0;
                        wb_valid    <= 1'b1;
                        wb_overflow <= ovf_q;
                        wb_compflg  <= cmp_q;
                        wb_control  <= ctrl_q;
                        if (dmem_ack) begin
                            wb_result <= wait_result;
                        end else begin
                            wb_result            <= '0;
                            wb_control.reg_write <= 1'b0;
                            bus_err              <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: directed vector table, randomized ops
// against a byte-level reference model, and reset corner cases.
module tb_memory_access_stage;
    import memory_access_stage_pkg::*;

    localparam int TMO = 4;

    logic        clk, rst_n;
    logic        ex_valid, ex_ready;
    control_type control_in;
    logic [31:0] alu_data_in, memory_data_in;
    logic        overflow_in, compflg_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    control_type wb_control;
    logic [31:0] wb_result;
    logic        wb_overflow, wb_compflg, misalign_err, bus_err;

    memory_access_stage #(.ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .control_in(control_in), .alu_data_in(alu_data_in), .memory_data_in(memory_data_in),
        .overflow_in(overflow_in), .compflg_in(compflg_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_control(wb_control), .wb_result(wb_result),
        .wb_overflow(wb_overflow), .wb_compflg(wb_compflg),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        control_type ctrl;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        int          delay;   // ack on this 0-based request cycle; >= TMO means never
        logic        ovf;
        logic        cmp;
    } op_t;

    typedef struct packed {
        int          reqc;
        logic        we;
        logic [31:0] baddr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] result;
        logic        regwr;
        logic        mis;
        logic        berr;
    } exp_t;

    typedef struct packed {
        op_t  op;
        exp_t ex;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic control_type mk(input logic rd, input logic wr, input mem_size_t sz,
                                       input logic uns, input logic rw, input logic m2r);
        control_type c;
        c.mem_read = rd; c.mem_write = wr; c.mem_size = sz;
        c.mem_unsigned = uns; c.reg_write = rw; c.mem_to_reg = m2r;
        return c;
    endfunction

    function automatic op_t mkop(input control_type c, input logic [31:0] a, input logic [31:0] d,
                                 input logic [31:0] rd, input int dl, input logic ov, input logic cf);
        op_t o;
        o.ctrl = c; o.addr = a; o.data = d; o.rdata = rd; o.delay = dl; o.ovf = ov; o.cmp = cf;
        return o;
    endfunction

    function automatic exp_t mkexp(input int rc, input logic we, input logic [31:0] ba,
                                   input logic [31:0] wd, input logic [3:0] be, input logic [31:0] res,
                                   input logic rw, input logic mis, input logic be_err);
        exp_t e;
        e.reqc = rc; e.we = we; e.baddr = ba; e.wdata = wd; e.be = be; e.result = res;
        e.regwr = rw; e.mis = mis; e.berr = be_err;
        return e;
    endfunction

    // Reference: byte counts, lane offsets and 64-bit masking rather than per-size muxes.
    function automatic exp_t model(input op_t o);
        exp_t e;
        int n, off;
        logic [63:0] v, msk;
        e = '0;
        n = (o.ctrl.mem_size == MEM_BYTE) ? 1 : (o.ctrl.mem_size == MEM_HALF) ? 2 : 4;
        off = int'(o.addr % 4);
        e.result = o.addr;
        e.regwr  = o.ctrl.reg_write;
        if (!(o.ctrl.mem_read || o.ctrl.mem_write)) return e;
        if (off % n != 0) begin
            e.mis = 1'b1; e.regwr = 1'b0;
            return e;
        end
        e.reqc  = (o.delay < TMO) ? o.delay + 1 : TMO;
        e.berr  = (o.delay >= TMO);
        e.we    = o.ctrl.mem_write;
        e.baddr = o.addr - 32'(off);
        e.be    = 4'(((1 << n) - 1) << off);
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = o.data[8*(i % n) +: 8];
        msk = (64'd1 << (8*n)) - 64'd1;
        v = 64'(o.rdata >> (8*off)) & msk;
        if (!o.ctrl.mem_unsigned && v[8*n-1]) v = v | ~msk;
        if (e.berr) begin
            e.result = '0; e.regwr = 1'b0;
        end else if (o.ctrl.mem_read && !o.ctrl.mem_write && o.ctrl.mem_to_reg) begin
            e.result = v[31:0];
        end
        return e;
    endfunction

    // Issue one op at a negedge, act as the bus slave, then check the writeback pulse.
    task automatic run_op(input op_t o, input exp_t e, input string tag);
        int cyc, reqc, rdy_low;
        logic got, stable;
        logic [31:0] c_addr, c_wdata;
        logic [3:0]  c_be;
        logic        c_we;
        control_type ec;
        control_in = o.ctrl; alu_data_in = o.addr; memory_data_in = o.data;
        overflow_in = o.ovf; compflg_in = o.cmp; ex_valid = 1'b1;
        dmem_ack = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        @(negedge clk);
        ex_valid = 1'b0;
        control_in = control_type'($urandom); alu_data_in = $urandom; memory_data_in = $urandom;
        overflow_in = 1'($urandom); compflg_in = 1'($urandom);
        cyc = 0; reqc = 0; rdy_low = 0; got = 1'b0; stable = 1'b1;
        c_addr = '0; c_wdata = '0; c_be = '0; c_we = 1'b0;
        while (cyc < 40 && !got) begin
            if (wb_valid) begin
                got = 1'b1;
            end else begin
                if (dmem_req) begin
                    if (reqc == 0) begin
                        c_addr = dmem_addr; c_wdata = dmem_wdata; c_be = dmem_be; c_we = dmem_we;
                    end else if (dmem_addr !== c_addr || dmem_wdata !== c_wdata ||
                                 dmem_be !== c_be || dmem_we !== c_we) begin
                        stable = 1'b0;
                    end
                    dmem_ack   = (reqc == o.delay);
                    dmem_rdata = (reqc == o.delay) ? o.rdata : $urandom;
                    reqc++;
                end else begin
                    dmem_ack = 1'($urandom_range(0, 1));
                end
                if (!ex_ready) rdy_low++;
                @(negedge clk);
                cyc++;
            end
        end
        dmem_ack = 1'b0;
        chk({tag, " wb_valid_seen"}, 32'(got), 32'd1);
        chk({tag, " req_cycles"}, 32'(reqc), 32'(e.reqc));
        chk({tag, " ready_low_cycles"}, 32'(rdy_low), 32'(e.reqc));
        if (e.reqc > 0) begin
            chk({tag, " dmem_addr"}, c_addr, e.baddr);
            chk({tag, " dmem_we"}, 32'(c_we), 32'(e.we));
            chk({tag, " dmem_be"}, 32'(c_be), 32'(e.be));
            if (e.we) chk({tag, " dmem_wdata"}, c_wdata, e.wdata);
            chk({tag, " bus_stable"}, 32'(stable), 32'd1);
        end
        ec = o.ctrl;
        ec.reg_write = e.regwr;
        chk({tag, " wb_result"}, wb_result, e.result);
        chk({tag, " wb_control"}, 32'(wb_control), 32'(ec));
        chk({tag, " wb_overflow"}, 32'(wb_overflow), 32'(o.ovf));
        chk({tag, " wb_compflg"}, 32'(wb_compflg), 32'(o.cmp));
        chk({tag, " misalign_err"}, 32'(misalign_err), 32'(e.mis));
        chk({tag, " bus_err"}, 32'(bus_err), 32'(e.berr));
        chk({tag, " ex_ready_at_wb"}, 32'(ex_ready), 32'd1);
        @(negedge clk);
        chk({tag, " wb_valid_pulse"}, 32'(wb_valid), 32'd0);
        chk({tag, " wb_result_hold"}, wb_result, e.result);
        chk({tag, " err_flags_clear"}, 32'({misalign_err, bus_err}), 32'd0);
    endtask

    vec_t tab[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t  o;
        logic quiet;
        tab[0].op = mkop(mk(0,0,MEM_WORD,0,1,0), 32'h0000_1234, 32'h0, 32'h0, 0, 1'b1, 1'b0);
        tab[0].ex = mkexp(0, 0, 32'h0, 32'h0, 4'h0, 32'h0000_1234, 1, 0, 0);
        tab[1].op = mkop(mk(1,0,MEM_BYTE,0,1,1), 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 3, 1'b0, 1'b1);
        tab[1].ex = mkexp(4, 0, 32'h0000_0100, 32'h0, 4'b1000, 32'hFFFF_FF80, 1, 0, 0);
        tab[2].op = mkop(mk(0,1,MEM_HALF,0,0,0), 32'h0000_0102, 32'hDEAD_BEEF, 32'h0, 1, 1'b0, 1'b0);
        tab[2].ex = mkexp(2, 1, 32'h0000_0100, 32'hBEEF_BEEF, 4'b1100, 32'h0000_0102, 0, 0, 0);
        tab[3].op = mkop(mk(1,0,MEM_WORD,0,1,1), 32'h0000_0101, 32'h0, 32'h0, 0, 1'b1, 1'b1);
        tab[3].ex = mkexp(0, 0, 32'h0, 32'h0, 4'h0, 32'h0000_0101, 0, 1, 0);
        tab[4].op = mkop(mk(1,0,MEM_WORD,0,1,1), 32'h0000_0200, 32'h0, 32'h1111_1111, 99, 1'b0, 1'b0);
        tab[4].ex = mkexp(4, 0, 32'h0000_0200, 32'h0, 4'b1111, 32'h0, 0, 0, 1);
        tab[5].op = mkop(mk(1,0,MEM_WORD,0,1,1), 32'h0000_0204, 32'h0, 32'h1234_5678, 3, 1'b0, 1'b0);
        tab[5].ex = mkexp(4, 0, 32'h0000_0204, 32'h0, 4'b1111, 32'h1234_5678, 1, 0, 0);
        tab[6].op = mkop(mk(1,0,MEM_HALF,1,1,1), 32'h0000_0106, 32'h0, 32'h8001_0000, 0, 1'b0, 1'b0);
        tab[6].ex = mkexp(1, 0, 32'h0000_0104, 32'h0, 4'b1100, 32'h0000_8001, 1, 0, 0);
        tab[7].op = mkop(mk(1,0,MEM_HALF,0,1,1), 32'h0000_0106, 32'h0, 32'h8001_0000, 2, 1'b1, 1'b0);
        tab[7].ex = mkexp(3, 0, 32'h0000_0104, 32'h0, 4'b1100, 32'hFFFF_8001, 1, 0, 0);
        tab[8].op = mkop(mk(1,1,MEM_BYTE,0,0,0), 32'h0000_0001, 32'h0000_00AB, 32'h0, 0, 1'b0, 1'b1);
        tab[8].ex = mkexp(1, 1, 32'h0000_0000, 32'hABAB_ABAB, 4'b0010, 32'h0000_0001, 0, 0, 0);

        rst_n = 1'b0; ex_valid = 1'b0; control_in = '0; alu_data_in = '0; memory_data_in = '0;
        overflow_in = 1'b0; compflg_in = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
        @(negedge clk); @(negedge clk);
        chk("reset dmem_req", 32'(dmem_req), 32'd0);
        chk("reset wb_valid", 32'(wb_valid), 32'd0);
        chk("reset ex_ready", 32'(ex_ready), 32'd1);
        chk("reset wb_result", wb_result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_op(tab[i].op, tab[i].ex, $sformatf("vec%0d", i));

        for (int i = 0; i < 80; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            o.ctrl = mk(kind == 1 || kind == 3, kind >= 2, mem_size_t'($urandom_range(0, 2)),
                        1'($urandom), 1'($urandom), 1'($urandom));
            o.addr  = $urandom;
            if ($urandom_range(0, 1) == 1) o.addr[1:0] = 2'b00;
            o.data  = $urandom;
            o.rdata = $urandom;
            o.delay = $urandom_range(0, TMO + 1);
            o.ovf   = 1'($urandom);
            o.cmp   = 1'($urandom);
            run_op(o, model(o), $sformatf("rnd%0d", i));
        end

        // Reset asserted mid-access must drop the request immediately and lose the op.
        control_in = mk(1,0,MEM_WORD,0,1,1); alu_data_in = 32'h0000_0300; ex_valid = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0;
        chk("midrst req_before", 32'(dmem_req), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst dmem_req", 32'(dmem_req), 32'd0);
        chk("midrst ex_ready", 32'(ex_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_ack = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wb_valid || dmem_req) quiet = 1'b0;
        end
        dmem_ack = 1'b0;
        chk("midrst no_wb_after", 32'(quiet), 32'd1);
        run_op(tab[1].op, tab[1].ex, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
